mips_decode_execute: RTL and testbench

//  Main control decode, ALU control and ALU for the 5-stage MIPS pipeline, sitting between the IF/ID and EX/MEM registers.
//  It decodes the opcode in ID and latches the control word, operands and immediate into an internal ID/EX register.
//  It then computes the ALU result, zero flag and branch target in EX.

---
 rtl/mips_decode_execute.sv | 182 ++++++++++++++++++
 tb/tb_mips_decode_execute.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_decode_execute.sv
// Decode/execute slice of the 5-stage MIPS pipeline.
// Main control decode in ID, an ID/EX register, then ALU control, ALU and branch target in EX.
module mips_decode_execute (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc_plus4,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    output logic [9:0]  id_control,
    output logic        ex_reg_write,
    output logic        ex_mem_to_reg,
    output logic        ex_branch,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_half,
    output logic        ex_half_unsigned,
    output logic [4:0]  ex_dest_reg,
    output logic [31:0] ex_alu_out,
    output logic        ex_zero,
    output logic [31:0] ex_branch_addr,
    output logic [31:0] ex_store_data
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;

    logic [5:0]  opcode;
    logic [15:0] imm16;
    logic        id_half;
    logic        id_half_unsigned;
    logic        id_zext;
    logic [31:0] id_ext_imm;

    // rs index is consumed by the register file upstream, not here
    logic unused_rs_idx;
    assign unused_rs_idx = ^id_instr[25:21];

    assign opcode = id_instr[31:26];
    assign imm16  = id_instr[15:0];

    // id_control = {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp[2:0]}
    always_comb begin
        id_control       = 10'b0;
        id_half          = 1'b0;
        id_half_unsigned = 1'b0;
        id_zext          = 1'b0;
        case (opcode)
            6'h00: id_control = 10'b1_0_0_1_0_0_0_010;
            6'h08: id_control = 10'b0_1_0_1_0_0_0_000;
            6'h0C: begin
                id_control = 10'b0_1_0_1_0_0_0_011;
                id_zext    = 1'b1;
            end
            6'h0D: begin
                id_control = 10'b0_1_0_1_0_0_0_100;
                id_zext    = 1'b1;
            end
            6'h23: id_control = 10'b0_1_1_1_1_0_0_000;
            6'h21: begin
                id_control = 10'b0_1_1_1_1_0_0_000;
                id_half    = 1'b1;
            end
            6'h25: begin
                id_control       = 10'b0_1_1_1_1_0_0_000;
                id_half          = 1'b1;
                id_half_unsigned = 1'b1;
            end
            6'h2B: id_control = 10'b0_1_0_0_0_1_0_000;
            6'h04: id_control = 10'b0_0_0_0_0_0_1_001;
            default: id_control = 10'b0;
        endcase
    end

    assign id_ext_imm = id_zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};

    logic [9:0]  ctrl_q;
    logic        half_q;
    logic        half_unsigned_q;
    logic [31:0] pc_plus4_q;
    logic [31:0] rs_data_q;
    logic [31:0] rt_data_q;
    logic [31:0] ext_imm_q;
    logic [4:0]  rt_idx_q;
    logic [4:0]  rd_idx_q;
    logic [4:0]  shamt_q;
    logic [5:0]  funct_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q          <= '0;
            half_q          <= 1'b0;
            half_unsigned_q <= 1'b0;
            pc_plus4_q      <= '0;
            rs_data_q       <= '0;
            rt_data_q       <= '0;
            ext_imm_q       <= '0;
            rt_idx_q        <= '0;
            rd_idx_q        <= '0;
            shamt_q         <= '0;
            funct_q         <= '0;
        end else if (en) begin
            ctrl_q          <= id_control;
            half_q          <= id_half;
            half_unsigned_q <= id_half_unsigned;
            pc_plus4_q      <= id_pc_plus4;
            rs_data_q       <= id_rs_data;
            rt_data_q       <= id_rt_data;
            ext_imm_q       <= id_ext_imm;
            rt_idx_q        <= id_instr[20:16];
            rd_idx_q        <= id_instr[15:11];
            shamt_q         <= id_instr[10:6];
            funct_q         <= id_instr[5:0];
        end
    end

    logic [3:0]  alu_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;

    always_comb begin
        alu_sel = ALU_ADD;
        case (ctrl_q[2:0])
            3'b000: alu_sel = ALU_ADD;
            3'b001: alu_sel = ALU_SUB;
            3'b011: alu_sel = ALU_AND;
            3'b100: alu_sel = ALU_OR;
            3'b010: begin
                case (funct_q)
                    6'h20: alu_sel = ALU_ADD;
                    6'h22: alu_sel = ALU_SUB;
                    6'h24: alu_sel = ALU_AND;
                    6'h25: alu_sel = ALU_OR;
                    6'h2A: alu_sel = ALU_SLT;
                    6'h2B: alu_sel = ALU_SLTU;
                    6'h00: alu_sel = ALU_SLL;
                    6'h02: alu_sel = ALU_SRL;
                    default: alu_sel = ALU_ADD;
                endcase
            end
            default: alu_sel = ALU_ADD;
        endcase
    end

    assign alu_a = rs_data_q;
    assign alu_b = ctrl_q[8] ? ext_imm_q : rt_data_q;

    always_comb begin
        ex_alu_out = alu_a + alu_b;
        case (alu_sel)
            ALU_SUB:  ex_alu_out = alu_a - alu_b;
            ALU_AND:  ex_alu_out = alu_a & alu_b;
            ALU_OR:   ex_alu_out = alu_a | alu_b;
            ALU_SLT:  ex_alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: ex_alu_out = {31'b0, alu_a < alu_b};
            ALU_SLL:  ex_alu_out = alu_b << shamt_q;
            ALU_SRL:  ex_alu_out = alu_b >> shamt_q;
            default:  ex_alu_out = alu_a + alu_b;
        endcase
    end

    assign ex_zero          = (ex_alu_out == 32'b0);
    assign ex_reg_write     = ctrl_q[6];
    assign ex_mem_to_reg    = ctrl_q[7];
    assign ex_mem_read      = ctrl_q[5];
    assign ex_mem_write     = ctrl_q[4];
    assign ex_branch        = ctrl_q[3];
    assign ex_half          = half_q;
    assign ex_half_unsigned = half_unsigned_q;
    assign ex_dest_reg      = ctrl_q[9] ? rd_idx_q : rt_idx_q;
    assign ex_store_data    = rt_data_q;
    // Branch offset is always sign-extended, even when the ALU used a zero-extended immediate
    assign ex_branch_addr   = pc_plus4_q + {{14{ext_imm_q[15]}}, ext_imm_q[15:0], 2'b00};

endmodule

// File: tb/tb_mips_decode_execute.sv
// Randomized self-checking bench for mips_decode_execute against an instruction-level reference model.
module tb_mips_decode_execute;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [9:0]  id_control;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic        ex_branch;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_half;
    logic        ex_half_unsigned;
    logic [4:0]  ex_dest_reg;
    logic [31:0] ex_alu_out;
    logic        ex_zero;
    logic [31:0] ex_branch_addr;
    logic [31:0] ex_store_data;

    mips_decode_execute dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .id_instr         (id_instr),
        .id_pc_plus4      (id_pc_plus4),
        .id_rs_data       (id_rs_data),
        .id_rt_data       (id_rt_data),
        .id_control       (id_control),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_to_reg    (ex_mem_to_reg),
        .ex_branch        (ex_branch),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_half          (ex_half),
        .ex_half_unsigned (ex_half_unsigned),
        .ex_dest_reg      (ex_dest_reg),
        .ex_alu_out       (ex_alu_out),
        .ex_zero          (ex_zero),
        .ex_branch_addr   (ex_branch_addr),
        .ex_store_data    (ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        half;
        logic        half_unsigned;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] baddr;
        logic [31:0] store;
    } ex_t;

    int   n_checks = 0;
    int   n_errors = 0;
    ex_t  exp_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected control word from the instruction mnemonic
    function automatic logic [9:0] ctrl_model(input logic [31:0] instr);
        logic reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
        logic [2:0] alu_op;
        {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch} = '0;
        alu_op = 3'b000;
        case (instr[31:26])
            6'h00: begin reg_dst = 1; reg_write = 1; alu_op = 3'b010; end
            6'h08: begin alu_src = 1; reg_write = 1; end
            6'h0C: begin alu_src = 1; reg_write = 1; alu_op = 3'b011; end
            6'h0D: begin alu_src = 1; reg_write = 1; alu_op = 3'b100; end
            6'h23, 6'h21, 6'h25: begin
                alu_src = 1; mem_to_reg = 1; reg_write = 1; mem_read = 1;
            end
            6'h2B: begin alu_src = 1; mem_write = 1; end
            6'h04: begin branch = 1; alu_op = 3'b001; end
            default: ;
        endcase
        return {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op};
    endfunction

    // Architectural result of executing one instruction
    function automatic ex_t ex_model(input logic [31:0] instr, input logic [31:0] pc,
                                     input logic [31:0] rs, input logic [31:0] rt);
        ex_t e;
        logic [31:0] sx, zx;
        int unsigned sh;
        sx = {{16{instr[15]}}, instr[15:0]};
        zx = {16'h0000, instr[15:0]};
        sh = instr[10:6];
        e = '0;
        e.store = rt;
        e.baddr = pc + sx * 4;
        e.dest  = instr[20:16];
        e.alu   = rs + rt;
        case (instr[31:26])
            6'h00: begin
                e.reg_write = 1;
                e.dest = instr[15:11];
                case (instr[5:0])
                    6'h22: e.alu = rs - rt;
                    6'h24: e.alu = rs & rt;
                    6'h25: e.alu = rs | rt;
                    6'h2A: e.alu = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                    6'h2B: e.alu = (rs < rt) ? 32'd1 : 32'd0;
                    6'h00: e.alu = rt << sh;
                    6'h02: e.alu = rt >> sh;
                    default: e.alu = rs + rt;
                endcase
            end
            6'h08: begin e.reg_write = 1; e.alu = rs + sx; end
            6'h0C: begin e.reg_write = 1; e.alu = rs & zx; end
            6'h0D: begin e.reg_write = 1; e.alu = rs | zx; end
            6'h23, 6'h21, 6'h25: begin
                e.reg_write = 1; e.mem_to_reg = 1; e.mem_read = 1;
                e.half = (instr[31:26] != 6'h23);
                e.half_unsigned = (instr[31:26] == 6'h25);
                e.alu = rs + sx;
            end
            6'h2B: begin e.mem_write = 1; e.alu = rs + sx; end
            6'h04: begin e.branch = 1; e.alu = rs - rt; end
            default: ;
        endcase
        e.zero = (e.alu == 32'd0);
        return e;
    endfunction

    function automatic ex_t reset_model();
        ex_t e;
        e = '0;
        e.zero = 1'b1;
        return e;
    endfunction

    task automatic check_ex();
        chk("ex_reg_write",     {31'b0, ex_reg_write},     {31'b0, exp_q.reg_write});
        chk("ex_mem_to_reg",    {31'b0, ex_mem_to_reg},    {31'b0, exp_q.mem_to_reg});
        chk("ex_branch",        {31'b0, ex_branch},        {31'b0, exp_q.branch});
        chk("ex_mem_read",      {31'b0, ex_mem_read},      {31'b0, exp_q.mem_read});
        chk("ex_mem_write",     {31'b0, ex_mem_write},     {31'b0, exp_q.mem_write});
        chk("ex_half",          {31'b0, ex_half},          {31'b0, exp_q.half});
        chk("ex_half_unsigned", {31'b0, ex_half_unsigned}, {31'b0, exp_q.half_unsigned});
        chk("ex_dest_reg",      {27'b0, ex_dest_reg},      {27'b0, exp_q.dest});
        chk("ex_alu_out",       ex_alu_out,                exp_q.alu);
        chk("ex_zero",          {31'b0, ex_zero},          {31'b0, exp_q.zero});
        chk("ex_branch_addr",   ex_branch_addr,            exp_q.baddr);
        chk("ex_store_data",    ex_store_data,             exp_q.store);
    endtask

    // Drive one cycle of inputs, check decode, clock it, check the EX view
    task automatic step(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs,
                        input logic [31:0] rt, input logic e, input logic r);
        id_instr = instr; id_pc_plus4 = pc; id_rs_data = rs; id_rt_data = rt;
        en = e; rst = r;
        #1;
        chk("id_control", {22'b0, id_control}, {22'b0, ctrl_model(instr)});
        @(posedge clk);
        if (r)      exp_q = reset_model();
        else if (e) exp_q = ex_model(instr, pc, rs, rt);
        #1;
        check_ex();
    endtask

    logic [5:0] op_tab [10] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h21, 6'h25, 6'h2B, 6'h04, 6'h3F};
    logic [5:0] fn_tab [9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h3F};

    initial begin
        exp_q = reset_model();
        step(32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        step(32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("reset_zero", {31'b0, ex_zero}, 32'd1);

        step(32'h20100032, 32'd4, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("addi_alu", ex_alu_out, 32'd50);
        chk("addi_dest", {27'b0, ex_dest_reg}, 32'd16);

        step(32'h0000002A, 32'd8, 32'hFFFFFF9C, 32'd50, 1'b1, 1'b0);
        chk("slt_neg", ex_alu_out, 32'd1);
        step(32'h0000002B, 32'd8, 32'hFFFFFF9C, 32'd50, 1'b1, 1'b0);
        chk("sltu_neg", ex_alu_out, 32'd0);
        step(32'h00000020, 32'd8, 32'hFFFFFF9C, 32'd50, 1'b1, 1'b0);
        chk("add_neg", ex_alu_out, 32'hFFFFFFCE);

        step(32'h0014A400, 32'd12, 32'd0, 32'hFFFFFF9C, 1'b1, 1'b0);
        chk("sll_alu", ex_alu_out, 32'hFF9C0000);
        step(32'h0014A402, 32'd12, 32'd0, 32'hFFFFFF9C, 1'b1, 1'b0);
        chk("srl_alu", ex_alu_out, 32'h0000FFFF);

        step(32'h10000005, 32'd140, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("beq_addr", ex_branch_addr, 32'd160);
        step(32'h1000FFFF, 32'd0, 32'd7, 32'd3, 1'b1, 1'b0);
        chk("beq_wrap", ex_branch_addr, 32'hFFFFFFFC);

        step(32'h32AFFFFF, 32'd16, 32'h12345678, 32'd0, 1'b1, 1'b0);
        chk("andi_zext", ex_alu_out, 32'h00005678);
        step(32'h94080010, 32'd20, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("lhu_alu", ex_alu_out, 32'd16);

        step(32'h20100032, 32'd4, 32'd0, 32'd0, 1'b1, 1'b0);
        step(32'h20100032, 32'd4, 32'd0, 32'd0, 1'b1, 1'b1);
        chk("rst_over_en", {31'b0, ex_reg_write}, 32'd0);
        step(32'h20100032, 32'd4, 32'd0, 32'd0, 1'b1, 1'b0);
        step(32'h0000002A, 32'd8, 32'd1, 32'd2, 1'b0, 1'b0);
        chk("hold_alu", ex_alu_out, 32'd50);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] instr, rs, rt;
            instr = $urandom;
            instr[31:26] = op_tab[$urandom_range(0, 9)];
            if (instr[31:26] == 6'h3F) instr[31:26] = 6'($urandom);
            if (instr[31:26] == 6'h00 && $urandom_range(0, 4) != 0)
                instr[5:0] = fn_tab[$urandom_range(0, 8)];
            rs = $urandom;
            rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
            if ($urandom_range(0, 5) == 0) rs = 32'd0;
            step(instr, $urandom, rs, rt, ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
